// File: rtl/w0_fifo_pkg.sv
// Shared constants and types for the w0 128-bit first-word-fall-through FIFO.
// Optional sticky error flags are enabled with the W0_FIFO_ERR_EN macro.
package w0_fifo_pkg;

    localparam int unsigned W0_DATA_W            = 128;
    localparam int unsigned W0_DEPTH             = 512;
    localparam int unsigned W0_PROG_EMPTY_THRESH = 128;
    localparam int unsigned W0_PROG_FULL_THRESH  = 256;

    // Pointer width and count width (count needs one extra bit to hold DEPTH)
    localparam int unsigned W0_ADDR_W = $clog2(W0_DEPTH);
    localparam int unsigned W0_CNT_W  = W0_ADDR_W + 1;

    typedef logic [W0_DATA_W-1:0] word_t;

endpackage

// File: rtl/w0_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module w0_fifo_ram
    import w0_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = W0_DATA_W,
    parameter int unsigned DEPTH  = W0_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/w0_sync_fifo_128.sv
// Single-clock FWFT FIFO with programmable empty/full flags for AXI burst pacing.
// Defining W0_FIFO_ERR_EN adds sticky overflow_o / underflow_o outputs.
module w0_sync_fifo_128
    import w0_fifo_pkg::*;
#(
    parameter int unsigned DATA_W            = W0_DATA_W,
    parameter int unsigned DEPTH             = W0_DEPTH,
    parameter int unsigned PROG_EMPTY_THRESH = W0_PROG_EMPTY_THRESH,
    parameter int unsigned PROG_FULL_THRESH  = W0_PROG_FULL_THRESH
) (
    input  logic              clk_i,
    input  logic              a_rst_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wdata,
    output logic              full_o,
    output logic              prog_full_o,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rdata,
    output logic              empty_o,
    output logic              prog_empty_o
`ifdef W0_FIFO_ERR_EN
    ,
    output logic              overflow_o,
    output logic              underflow_o
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] ram_rdata;
    logic              wr_acc;
    logic              rd_acc;

    // Acceptance is judged against the flags of the current cycle only
    assign wr_acc = wr_en_i & ~full_o;
    assign rd_acc = rd_en_i & ~empty_o;

    // Pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk_i or posedge a_rst_i) begin
        if (a_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Flags decode the registered count directly
    assign empty_o      = (count == '0);
    assign full_o       = (count == CNT_W'(DEPTH));
    assign prog_empty_o = (count <  CNT_W'(PROG_EMPTY_THRESH));
    assign prog_full_o  = (count >= CNT_W'(PROG_FULL_THRESH));

    w0_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk_i),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // Head word falls through; storage is not cleared, so mask stale data when empty
    assign rdata = empty_o ? '0 : ram_rdata;

`ifdef W0_FIFO_ERR_EN
    // Sticky misuse indicators, cleared only by reset
    always_ff @(posedge clk_i or posedge a_rst_i) begin
        if (a_rst_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (wr_en_i && full_o) begin
                overflow_o <= 1'b1;
            end
            if (rd_en_i && empty_o) begin
                underflow_o <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_w0_sync_fifo_128.sv
// Self-checking bench for w0_sync_fifo_128: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_w0_sync_fifo_128;
    import w0_fifo_pkg::*;

    localparam int unsigned DEPTH = W0_DEPTH;

    logic  clk;
    logic  a_rst;
    logic  wr_en;
    logic  rd_en;
    word_t wdata;
    word_t rdata;
    logic  full, prog_full, empty, prog_empty;
`ifdef W0_FIFO_ERR_EN
    logic  overflow, underflow;
    logic  m_ovf, m_unf;
`endif

    word_t model_q[$];
    int    n_tests;
    int    n_fail;

    w0_sync_fifo_128 dut (
        .clk_i        (clk),
        .a_rst_i      (a_rst),
        .wr_en_i      (wr_en),
        .wdata        (wdata),
        .full_o       (full),
        .prog_full_o  (prog_full),
        .rd_en_i      (rd_en),
        .rdata        (rdata),
        .empty_o      (empty),
        .prog_empty_o (prog_empty)
`ifdef W0_FIFO_ERR_EN
        ,
        .overflow_o   (overflow),
        .underflow_o  (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t, model count %0d)",
                     tag, got, exp, $time, model_q.size());
        end
    endtask

    // Expected outputs follow directly from the model occupancy and head word
    task automatic check_outputs();
        int n;
        n = model_q.size();
        chk("empty",      128'(empty),      128'(n == 0));
        chk("full",       128'(full),       128'(n == int'(DEPTH)));
        chk("prog_empty", 128'(prog_empty), 128'(n < int'(W0_PROG_EMPTY_THRESH)));
        chk("prog_full",  128'(prog_full),  128'(n >= int'(W0_PROG_FULL_THRESH)));
        chk("rdata",      rdata,            (n == 0) ? 128'(0) : model_q[0]);
`ifdef W0_FIFO_ERR_EN
        chk("overflow",   128'(overflow),   128'(m_ovf));
        chk("underflow",  128'(underflow),  128'(m_unf));
`endif
    endtask

    // One clock cycle: check current outputs, drive inputs, then advance the model
    task automatic step(input logic we, input word_t wd, input logic re);
        int  n;
        logic w_ok, r_ok;
        @(negedge clk);
        check_outputs();
        wr_en = we;
        wdata = wd;
        rd_en = re;
        @(posedge clk);
        n    = model_q.size();
        w_ok = we && (n < int'(DEPTH));
        r_ok = re && (n > 0);
`ifdef W0_FIFO_ERR_EN
        if (we && n == int'(DEPTH)) m_ovf = 1'b1;
        if (re && n == 0)           m_unf = 1'b1;
`endif
        if (r_ok) void'(model_q.pop_front());
        if (w_ok) model_q.push_back(wd);
    endtask

    function automatic word_t rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drain();
        int guard;
        guard = 0;
        while (model_q.size() > 0 && guard < 2 * int'(DEPTH)) begin
            step(1'b0, '0, 1'b1);
            guard++;
        end
        chk("drain_done", 128'(model_q.size()), 128'(0));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wdata   = '0;
        a_rst   = 1'b1;
`ifdef W0_FIFO_ERR_EN
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        a_rst = 1'b0;

        // Reset state and idle
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);

        // Single word fall-through and pop
        step(1'b1, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // prog_empty boundary at 128
        for (int i = 0; i < 128; i++) step(1'b1, 128'(i), 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        drain();

        // Fill to full, overflow attempt, in-order drain across the wrap
        for (int i = 0; i < int'(DEPTH); i++) step(1'b1, 128'(i), 1'b0);
        step(1'b1, 128'hDEAD, 1'b0);
        step(1'b0, '0, 1'b0);
        drain();
        step(1'b0, '0, 1'b1);

        // Simultaneous read/write at full and at empty
        for (int i = 0; i < int'(DEPTH); i++) step(1'b1, rand_word(), 1'b0);
        step(1'b1, 128'hBEEF, 1'b1);
        step(1'b0, '0, 1'b0);
        drain();
        step(1'b1, 128'h77, 1'b1);
        step(1'b0, '0, 1'b0);
        drain();

        // Asynchronous reset with 300 words stored
        for (int i = 0; i < 300; i++) step(1'b1, rand_word(), 1'b0);
        @(negedge clk);
        check_outputs();
        wr_en = 1'b0;
        rd_en = 1'b0;
        #1 a_rst = 1'b1;
        #1;
        model_q.delete();
`ifdef W0_FIFO_ERR_EN
        m_ovf = 1'b0;
        m_unf = 1'b0;
`endif
        check_outputs();
        #1 a_rst = 1'b0;
        step(1'b1, 128'hA5A5, 1'b0);
        step(1'b1, 128'h5A5A, 1'b0);
        drain();

        // Random traffic with varying write/read pressure
        for (int seg = 0; seg < 8; seg++) begin
            int pw, pr;
            pw = (seg % 3 == 0) ? 85 : int'($urandom_range(30, 70));
            pr = (seg % 3 == 1) ? 85 : int'($urandom_range(30, 70));
            for (int c = 0; c < 500; c++) begin
                step(int'($urandom_range(0, 99)) < pw, rand_word(),
                     int'($urandom_range(0, 99)) < pr);
            end
        end
        drain();
        step(1'b0, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
